// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders + OR) reused LSB-first
// over WIDTH cycles, with start/busy/done handshake and held result registers.

module halfadder (
   input  logic x,
   input  logic y,
   output logic c,
   output logic s
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sa, sb, acc;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               c1, s1, c2, s;
   logic               load, last;

   halfadder ha1 (.x(sa[0]), .y(sb[0]), .c(c1), .s(s1));
   halfadder ha2 (.x(s1),    .y(carry), .c(c2), .s(s));

   assign last = (cnt == CNT_W'(WIDTH-1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else if (load) begin
         sa    <= a;
         sb    <= b;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (busy) begin
         carry <= c1 | c2;
         acc   <= {s, acc[WIDTH-1:1]};
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         cnt   <= cnt + 1'b1;
         // Result registers only move on the completing edge.
         if (last) begin
            sum  <= {s, acc[WIDTH-1:1]};
            cout <= c1 | c2;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 scenarios plus exhaustive
// back-to-back WIDTH=4 sweep on a second instance.

module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done;
   logic [7:0] sum;
   logic       cout;

   logic       start4;
   logic [3:0] a4, b4;
   logic       busy4, done4;
   logic [3:0] sum4;
   logic       cout4;

   int n_chk  = 0;
   int n_fail = 0;
   int n_done4 = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   always @(negedge clk) if (done4) n_done4++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present operands for one edge; returns at the negedge of busy cycle 1.
   task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
      @(negedge clk);
      start = 1'b1; a = va; b = vb;
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
   endtask

   // Entered at busy cycle 1; checks 8 busy cycles, the done cycle and result.
   task automatic run_chk(input logic [7:0] es, input logic ec, input bit inject,
                          input bit b2b, input logic [7:0] na, input logic [7:0] nb);
      for (int i = 1; i <= 8; i++) begin
         if (i > 1) @(negedge clk);
         chk("busy_run", busy, 1);
         chk("done_run", done, 0);
         if (inject && i == 3) begin
            start = 1'b1; a = 8'hAA; b = 8'hAA;
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 0);
      chk("sum", sum, es);
      chk("cout", cout, ec);
      if (b2b) begin
         start = 1'b1; a = na; b = nb;
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_single", done, 0);
      chk("busy_after", busy, b2b);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      rst = 1'b0;

      start_op(8'h00, 8'h00); run_chk(8'h00, 1'b0, 0, 0, 0, 0);
      start_op(8'h5A, 8'h33); run_chk(8'h8D, 1'b0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold_sum", sum, 8'h8D);
         chk("hold_done", done, 0);
      end
      start_op(8'hFF, 8'h01); run_chk(8'h00, 1'b1, 0, 0, 0, 0);
      start_op(8'hFF, 8'hFF); run_chk(8'hFE, 1'b1, 0, 0, 0, 0);

      // Ignored start mid-run, then back-to-back from the DONE cycle.
      start_op(8'h10, 8'h20); run_chk(8'h30, 1'b0, 1, 1, 8'h01, 8'h02);
      run_chk(8'h03, 1'b0, 0, 0, 0, 0);

      // Abort: reset during busy cycle 4.
      start_op(8'h7F, 8'h7F);
      for (int i = 1; i <= 4; i++) begin
         if (i > 1) @(negedge clk);
         chk("abort_busy", busy, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy0", busy, 0);
      chk("abort_done0", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_nodone", done, 0);
         chk("abort_idle", busy, 0);
      end

      // WIDTH=4: all pairs back-to-back.
      @(negedge clk);
      start4 = 1'b1; a4 = 4'd0; b4 = 4'd0;
      for (int p = 0; p < 256; p++) begin
         logic [3:0] pa, pb;
         pa = 4'(p >> 4); pb = 4'(p);
         @(negedge clk);
         start4 = 1'b0;
         repeat (3) @(negedge clk);
         chk("w4_busy", busy4, 1);
         @(negedge clk);
         chk("w4_done", done4, 1);
         chk("w4_result", {cout4, sum4}, 5'(pa) + 5'(pb));
         if (p < 255) begin
            start4 = 1'b1; a4 = 4'((p + 1) >> 4); b4 = 4'(p + 1);
         end
      end
      @(negedge clk);
      #1;
      chk("w4_done_count", n_done4, 256);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
